cpu_ctrl_fsm_p: RTL and testbench

Parametrised multi-cycle control FSM for the SimpleCPU datapath. It sequences fetch, decode and execute, and drives the PC, IR, data memory, register file and ALU controls. Compared with the fixed 16-bit controller, it adds:
- generic instruction, register-address, data and memory widths;
- ready-handshaked instruction and data memory with wait states and a timeout;
- JNZ and HALT/resume instructions;
- a sticky error state and a retired-instruction counter;
- fully defined outputs in every state (no X).

It sits between the instruction register output and the datapath control inputs.

---
 rtl/cpu_ctrl_fsm_p_if.sv | 49 ++++
 rtl/cpu_ctrl_fsm_p.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm_p.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_fsm_p_if.sv
// rtl/cpu_ctrl_fsm_p_if.sv - IR/memory/register-file control bundle between the controller and the datapath
interface cpu_ctrl_fsm_p_if #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 4,
    parameter int DATA_W  = 8,
    parameter int DMEM_AW = 8,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instruction;
    logic               I_ready;
    logic               D_ready;
    logic               RF_Rp_zero;
    logic               resume;

    logic               PC_clr;
    logic               PC_inc;
    logic               PC_ld;
    logic               I_rd;
    logic               IR_ld;
    logic [DMEM_AW-1:0] D_addr;
    logic               D_rd;
    logic               D_wr;
    logic [DATA_W-1:0]  RF_W_data;
    logic [1:0]         RF_sel;
    logic [REG_AW-1:0]  RF_W_addr;
    logic [REG_AW-1:0]  RF_Rp_addr;
    logic [REG_AW-1:0]  RF_Rq_addr;
    logic               RF_W_wr;
    logic               RF_Rp_rd;
    logic               RF_Rq_rd;
    logic [1:0]         alu_sel;
    logic               halted;
    logic               err;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  instruction, I_ready, D_ready, RF_Rp_zero, resume,
        output PC_clr, PC_inc, PC_ld, I_rd, IR_ld, D_addr, D_rd, D_wr,
               RF_W_data, RF_sel, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
               RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_sel, halted, err, retired
    );

    modport slave (
        output instruction, I_ready, D_ready, RF_Rp_zero, resume,
        input  PC_clr, PC_inc, PC_ld, I_rd, IR_ld, D_addr, D_rd, D_wr,
               RF_W_data, RF_sel, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
               RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_sel, halted, err, retired
    );
endinterface

// File: rtl/cpu_ctrl_fsm_p.sv
// rtl/cpu_ctrl_fsm_p.sv - multi-cycle fetch/decode/execute controller with memory wait timeout and retire count
module cpu_ctrl_fsm_p #(
    parameter int INSTR_W  = 16,
    parameter int REG_AW   = 4,
    parameter int DATA_W   = 8,
    parameter int DMEM_AW  = 8,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_ctrl_fsm_p_if.master bus
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_ADD    = 4'd5;
    localparam logic [3:0] S_LOC    = 4'd6;
    localparam logic [3:0] S_SUB    = 4'd7;
    localparam logic [3:0] S_JMZ    = 4'd8;
    localparam logic [3:0] S_JNZ    = 4'd9;
    localparam logic [3:0] S_NOT    = 4'd10;
    localparam logic [3:0] S_JMP    = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Timeout fires on the stall cycle that would bring the count up to MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [3:0]         state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               timeout;
    logic               mem_state;

    logic [3:0]         op;
    logic [REG_AW-1:0]  ra, rb, rc;
    logic [DMEM_AW-1:0] addr;
    logic [DATA_W-1:0]  imm;

    assign op   = bus.instruction[INSTR_W-1 -: 4];
    assign ra   = bus.instruction[INSTR_W-5 -: REG_AW];
    assign rb   = bus.instruction[2*REG_AW-1 : REG_AW];
    assign rc   = bus.instruction[REG_AW-1 : 0];
    assign addr = bus.instruction[DMEM_AW-1 : 0];
    assign imm  = bus.instruction[DATA_W-1 : 0];

    assign timeout   = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);
    assign mem_state = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);

    function automatic logic [3:0] op_state(input logic [3:0] o);
        case (o)
            4'd0:    op_state = S_LOAD;
            4'd1:    op_state = S_STORE;
            4'd2:    op_state = S_ADD;
            4'd3:    op_state = S_LOC;
            4'd4:    op_state = S_SUB;
            4'd5:    op_state = S_JMZ;
            4'd6:    op_state = S_NOT;
            4'd7:    op_state = S_JMP;
            4'd8:    op_state = S_JNZ;
            4'd9:    op_state = S_HALT;
            default: op_state = S_ERROR;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.I_ready)  state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                state_d = op_state(op);
                retire  = (op == 4'd9);
            end
            S_LOAD, S_STORE: begin
                if (bus.D_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_ADD, S_LOC, S_SUB, S_NOT, S_JMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JMZ: begin
                if (bus.RF_Rp_zero) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_JNZ: begin
                if (!bus.RF_Rp_zero) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_HALT:   if (bus.resume) state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    // Only a self-loop in a memory-wait state counts; any entry restarts from zero.
    always_comb begin
        wait_d    = '0;
        if (mem_state && (state_d == state_q)) wait_d = wait_q + 1'b1;
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_inc     = 1'b0;
        bus.PC_ld      = 1'b0;
        bus.I_rd       = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_rd       = 1'b0;
        bus.D_wr       = 1'b0;
        bus.RF_W_data  = '0;
        bus.RF_sel     = 2'b00;
        bus.RF_W_addr  = '0;
        bus.RF_Rp_addr = '0;
        bus.RF_Rq_addr = '0;
        bus.RF_W_wr    = 1'b0;
        bus.RF_Rp_rd   = 1'b0;
        bus.RF_Rq_rd   = 1'b0;
        bus.alu_sel    = 2'b00;
        case (state_q)
            S_INIT:  bus.PC_clr = 1'b1;
            S_FETCH: begin
                bus.I_rd   = 1'b1;
                bus.IR_ld  = bus.I_ready;
                bus.PC_inc = bus.I_ready;
            end
            S_LOAD: begin
                bus.D_addr    = addr;
                bus.D_rd      = 1'b1;
                bus.RF_W_addr = ra;
                bus.RF_sel    = 2'b01;
                bus.RF_W_wr   = bus.D_ready;
            end
            S_STORE: begin
                bus.D_addr     = addr;
                bus.D_wr       = 1'b1;
                bus.RF_Rp_addr = ra;
                bus.RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Rp_addr = rb;
                bus.RF_Rq_addr = rc;
                bus.RF_Rp_rd   = 1'b1;
                bus.RF_Rq_rd   = 1'b1;
                bus.RF_W_addr  = ra;
                bus.RF_W_wr    = 1'b1;
                bus.alu_sel    = (state_q == S_ADD) ? 2'b01 : 2'b10;
            end
            S_LOC: begin
                bus.RF_W_addr = ra;
                bus.RF_W_wr   = 1'b1;
                bus.RF_sel    = 2'b10;
                bus.RF_W_data = imm;
            end
            S_NOT: begin
                bus.RF_W_addr = ra;
                bus.RF_W_wr   = 1'b1;
                bus.alu_sel   = 2'b11;
            end
            S_JMZ, S_JNZ: begin
                bus.RF_Rp_addr = ra;
                bus.RF_Rp_rd   = 1'b1;
            end
            S_JMP:   bus.PC_ld = 1'b1;
            default: ;
        endcase
    end

    assign bus.halted  = (state_q == S_HALT);
    assign bus.err     = (state_q == S_ERROR);
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// tb/tb_cpu_ctrl_fsm_p.sv - randomized instruction stream checked cycle by cycle against a per-instruction timing model
module tb_cpu_ctrl_fsm_p;
    localparam int MAXW = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_p_if bus ();

    cpu_ctrl_fsm_p dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic        pc_clr, pc_inc, pc_ld, i_rd, ir_ld;
        logic [7:0]  d_addr;
        logic        d_rd, d_wr;
        logic [7:0]  w_data;
        logic [1:0]  rf_sel;
        logic [3:0]  w_addr, p_addr, q_addr;
        logic        w_wr, p_rd, q_rd;
        logic [1:0]  alu_sel;
        logic        halted, err;
        logic [15:0] retired;
    } out_t;

    typedef struct {
        bit          chk;
        logic        rst_n;
        logic [15:0] instr;
        logic        i_ready, d_ready, zero, resume;
        out_t        exp;
        int          pin;
    } cyc_t;

    cyc_t        sched[$];
    cyc_t        cur;
    bit          cur_valid = 1'b0;
    int          cur_idx   = 0;
    int unsigned ret_cnt   = 0;
    logic [15:0] cur_instr = '0;
    int          pending_pin = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    out_t        act;

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t blank();
        out_t e;
        e         = '0;
        e.retired = ret_cnt[15:0];
        return e;
    endfunction

    task automatic push(input out_t e, input logic ir, input logic dr, input logic z, input logic rs,
                        input logic rst = 1'b1, input bit chk = 1'b1);
        cyc_t c;
        c.chk     = chk;
        c.rst_n   = rst;
        c.instr   = cur_instr;
        c.i_ready = ir;
        c.d_ready = dr;
        c.zero    = z;
        c.resume  = rs;
        c.exp     = e;
        c.pin     = pending_pin;
        pending_pin = 0;
        sched.push_back(c);
    endtask

    task automatic init_cycle();
        out_t e;
        e        = blank();
        e.pc_clr = 1'b1;
        pending_pin = 4;
        push(e, rnd(), rnd(), rnd(), rnd());
    endtask

    // Reset is sampled at the end of a cycle that still shows the old state's outputs.
    task automatic reset_from(input out_t e);
        push(e, rnd(), 1'b0, rnd(), rnd(), 1'b0);
        ret_cnt = 0;
        init_cycle();
    endtask

    task automatic error_then_reset();
        out_t e;
        int   n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            e     = blank();
            e.err = 1'b1;
            if (i == 0) pending_pin = 3;
            push(e, rnd(), rnd(), rnd(), rnd());
        end
        e     = blank();
        e.err = 1'b1;
        reset_from(e);
    endtask

    task automatic fetch(input int n);
        out_t e;
        e      = blank();
        e.i_rd = 1'b1;
        for (int k = 0; k < n; k++) push(e, 1'b0, rnd(), rnd(), rnd());
        e.ir_ld  = 1'b1;
        e.pc_inc = 1'b1;
        push(e, 1'b1, rnd(), rnd(), rnd());
    endtask

    task automatic exec_instr(input logic [15:0] ins, input int n_i, input int n_d, input bit z,
                              input int halt_len, input int pin);
        out_t       e;
        logic [3:0] op, ra, rb, rc;
        logic [7:0] lo;
        bit         taken;
        op = ins[15:12];
        ra = ins[11:8];
        rb = ins[7:4];
        rc = ins[3:0];
        lo = ins[7:0];
        cur_instr = ins;
        fetch(n_i);
        push(blank(), rnd(), rnd(), rnd(), (op == 4'd9) ? 1'b1 : rnd());
        pending_pin = pin;
        e = blank();
        case (op)
            4'd0, 4'd1: begin
                e.d_addr = lo;
                if (op == 4'd0) begin
                    e.d_rd = 1'b1; e.w_addr = ra; e.rf_sel = 2'b01;
                end else begin
                    e.d_wr = 1'b1; e.p_addr = ra; e.p_rd = 1'b1;
                end
                for (int k = 0; k < n_d && k < MAXW; k++) push(e, rnd(), 1'b0, rnd(), rnd());
                if (n_d >= MAXW) begin
                    error_then_reset();
                end else begin
                    if (op == 4'd0) e.w_wr = 1'b1;
                    push(e, rnd(), 1'b1, rnd(), rnd());
                    ret_cnt++;
                end
            end
            4'd2, 4'd4: begin
                e.p_addr = rb; e.q_addr = rc; e.p_rd = 1'b1; e.q_rd = 1'b1;
                e.w_addr = ra; e.w_wr = 1'b1;
                e.alu_sel = (op == 4'd2) ? 2'b01 : 2'b10;
                push(e, rnd(), rnd(), rnd(), rnd());
                ret_cnt++;
            end
            4'd3: begin
                e.w_addr = ra; e.w_wr = 1'b1; e.rf_sel = 2'b10; e.w_data = lo;
                push(e, rnd(), rnd(), rnd(), rnd());
                ret_cnt++;
            end
            4'd6: begin
                e.w_addr = ra; e.w_wr = 1'b1; e.alu_sel = 2'b11;
                push(e, rnd(), rnd(), rnd(), rnd());
                ret_cnt++;
            end
            4'd7: begin
                e.pc_ld = 1'b1;
                push(e, rnd(), rnd(), rnd(), rnd());
                ret_cnt++;
            end
            4'd5, 4'd8: begin
                e.p_addr = ra; e.p_rd = 1'b1;
                push(e, rnd(), rnd(), z, rnd());
                taken = (op == 4'd5) ? z : !z;
                if (taken) begin
                    e = blank();
                    e.pc_ld = 1'b1;
                    push(e, rnd(), rnd(), rnd(), rnd());
                end
                ret_cnt++;
            end
            4'd9: begin
                ret_cnt++;
                for (int k = 0; k < halt_len; k++) begin
                    e = blank();
                    e.halted = 1'b1;
                    if (k == 0) pending_pin = 5;
                    push(e, rnd(), rnd(), rnd(), (k == halt_len - 1) ? 1'b1 : 1'b0);
                end
            end
            default: error_then_reset();
        endcase
    endtask

    task automatic load_reset();
        out_t e;
        cur_instr = 16'h0A55;
        fetch(1);
        push(blank(), rnd(), rnd(), rnd(), rnd());
        e = blank();
        e.d_addr = 8'h55; e.d_rd = 1'b1; e.w_addr = 4'hA; e.rf_sel = 2'b01;
        push(e, rnd(), 1'b0, rnd(), rnd());
        reset_from(e);
    endtask

    task automatic pin_check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL pin %s at cycle %0d: got %h required %h", name, cur_idx, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid && cur.chk) begin
            act.pc_clr  = bus.PC_clr;     act.pc_inc = bus.PC_inc;   act.pc_ld  = bus.PC_ld;
            act.i_rd    = bus.I_rd;       act.ir_ld  = bus.IR_ld;    act.d_addr = bus.D_addr;
            act.d_rd    = bus.D_rd;       act.d_wr   = bus.D_wr;     act.w_data = bus.RF_W_data;
            act.rf_sel  = bus.RF_sel;     act.w_addr = bus.RF_W_addr;
            act.p_addr  = bus.RF_Rp_addr; act.q_addr = bus.RF_Rq_addr;
            act.w_wr    = bus.RF_W_wr;    act.p_rd   = bus.RF_Rp_rd; act.q_rd   = bus.RF_Rq_rd;
            act.alu_sel = bus.alu_sel;    act.halted = bus.halted;   act.err    = bus.err;
            act.retired = bus.retired;
            n_checks++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL outputs at cycle %0d (instr %h): got %h expected %h",
                         cur_idx, cur.instr, act, cur.exp);
            end
            case (cur.pin)
                1: pin_check("loc_fields", 32'({bus.RF_W_data, bus.RF_W_addr, bus.RF_sel, bus.RF_W_wr}),
                             32'({8'h5A, 4'h3, 2'b10, 1'b1}));
                2: pin_check("retired_after_loc", 32'(bus.retired), 32'd1);
                3: pin_check("error_state", 32'({bus.err, bus.PC_clr, bus.I_rd, bus.halted, bus.PC_ld}),
                             32'(5'b10000));
                4: pin_check("init_state", 32'({bus.PC_clr, bus.retired, bus.err, bus.halted}),
                             32'({1'b1, 16'd0, 1'b0, 1'b0}));
                5: pin_check("halt_state", 32'({bus.halted, bus.I_rd, bus.err}), 32'(3'b100));
                6: pin_check("load_stall", 32'({bus.D_rd, bus.D_addr, bus.RF_W_wr}),
                             32'({1'b1, 8'h10, 1'b0}));
                default: ;
            endcase
        end
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        int          n_i, n_d;

        bus.instruction = '0;
        bus.I_ready     = 1'b0;
        bus.D_ready     = 1'b0;
        bus.RF_Rp_zero  = 1'b0;
        bus.resume      = 1'b0;

        push(blank(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(blank(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        init_cycle();

        exec_instr(16'h335A, 0, 0, 1'b0, 1, 1);
        pending_pin = 2;
        exec_instr(16'h0210, 0, 3, 1'b0, 1, 6);
        exec_instr(16'h5300, 1, 0, 1'b1, 1, 0);
        exec_instr(16'h8400, 0, 0, 1'b1, 1, 0);
        exec_instr(16'h5300, 0, 0, 1'b0, 1, 0);
        exec_instr(16'h8400, 2, 0, 1'b0, 1, 0);
        exec_instr(16'h2123, 0, 0, 1'b0, 1, 0);
        exec_instr(16'h4456, 0, 0, 1'b0, 1, 0);
        exec_instr(16'h6700, 0, 0, 1'b0, 1, 0);
        exec_instr(16'h1A33, 0, 1, 1'b0, 1, 0);
        exec_instr(16'h7000, 0, 0, 1'b0, 1, 0);
        exec_instr(16'h9000, 0, 0, 1'b0, 5, 0);
        exec_instr(16'h0E77, 0, MAXW - 1, 1'b0, 1, 0);
        exec_instr(16'h1B20, 0, MAXW, 1'b0, 1, 0);
        exec_instr(16'hC123, 0, 0, 1'b0, 1, 0);
        load_reset();

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) < 4) op = 4'($urandom_range(10, 15));
            else                           op = 4'($urandom_range(0, 9));
            ins = {op, 12'($urandom)};
            n_i = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 9) == 0) n_d = ($urandom_range(0, 1) == 1) ? MAXW : MAXW - 1;
            else                           n_d = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) load_reset();
            exec_instr(ins, n_i, n_d, rnd(), $urandom_range(1, 6), 0);
        end

        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n           = sched[i].rst_n;
            bus.instruction = sched[i].instr;
            bus.I_ready     = sched[i].i_ready;
            bus.D_ready     = sched[i].d_ready;
            bus.RF_Rp_zero  = sched[i].zero;
            bus.resume      = sched[i].resume;
            cur             = sched[i];
            cur_idx         = i;
            cur_valid       = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
